serial_bus_tx: RTL
==================

# serial_bus_tx

Initiator-side serializer for the serial bus. It accepts one parallel request containing an address and a data byte. It then drives the request onto the bus one bit per cycle: the address LSB-first in address mode, then the data byte LSB-first in data mode. It sits between the initiator's request logic and the shared `bus_data_out` / `bus_data_out_valid` / `bus_mode` lines that feed the target address decoders and targets.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: address bits per transaction.
- `DATA_WIDTH`, default 8: data bits per transaction.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request offered.
- `req_addr`  in  ADDR_WIDTH  target address.
- `req_data`  in  DATA_WIDTH  write byte.
- `req_ready`  out  1  block can accept a request.
- `bus_stall`  in  1  bus owner holds off; the current beat is not driven.
- `bus_data_out`  out  1  serial bit.
- `bus_data_out_valid`  out  1  `bus_data_out` is a real beat this cycle.
- `bus_mode`  out  1  1 = data phase, 0 = address phase or idle.
- `busy`  out  1  a transaction is in progress.
- `done`  out  1  one-cycle pulse when the final data beat has been sent.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - `req_ready`=1, `busy`=0, `bus_mode`=0, `bus_data_out_valid`=0, `bus_data_out`=0.
  - On `req_valid && req_ready`: load `addr_sh`←`req_addr` and `data_sh`←`req_data`, clear `bit_cnt`, go to ADDR.
- ADDR:
  - `bus_mode`=0, `bus_data_out`=`addr_sh[0]`, `bus_data_out_valid`=`!bus_stall`.
  - Each non-stalled cycle: shift `addr_sh` right by one and increment `bit_cnt`.
  - After beat ADDR_WIDTH-1 is sent: clear `bit_cnt`, go to DATA.
- DATA:
  - `bus_mode`=1, `bus_data_out`=`data_sh[0]`, `bus_data_out_valid`=`!bus_stall`.
  - Each non-stalled cycle: shift `data_sh` and increment `bit_cnt`.
  - After beat DATA_WIDTH-1 is sent: go to IDLE and register `done`=1 for that next cycle.
- Stall:
  - While `bus_stall`=1, shift registers and `bit_cnt` hold and `bus_data_out_valid`=0.
  - `bus_mode` and `bus_data_out` hold their current-phase values.
  - A stall has no effect in IDLE.
- `bit_cnt` is `$clog2(max(ADDR_WIDTH,DATA_WIDTH))` bits wide and never wraps; its terminal compare is width-exact.
- `busy` = (state != IDLE).
- `req_ready`=0 in ADDR and DATA. A request presented while busy is not captured, and the requester must hold it.
- Request fields are sampled only on the accept edge. Later changes to `req_addr` or `req_data` do not affect the transaction in flight.
- The output sequence per transaction is exactly ADDR_WIDTH valid beats with `bus_mode`=0 followed by DATA_WIDTH valid beats with `bus_mode`=1. This matches the target decoder, which counts exactly DATA_WIDTH data beats before releasing selection.

## Timing
- Reset:
  - State goes to IDLE; all shift registers and counters clear.
  - Outputs after reset: `req_ready`=1, `busy`=0, `done`=0, `bus_mode`=0, `bus_data_out_valid`=0, `bus_data_out`=0.
- Reset mid-transaction aborts on the next edge. Outputs return to the reset values and no `done` pulse is produced.
- With the request accepted at edge T and no stalls:
  - Address beats are in cycles T+1 … T+ADDR_WIDTH.
  - Data beats are in cycles T+ADDR_WIDTH+1 … T+ADDR_WIDTH+DATA_WIDTH.
  - `done`=1 and `req_ready`=1 in cycle T+ADDR_WIDTH+DATA_WIDTH+1.
- `done` and `req_ready` are both high in the same cycle. If `req_valid` is high then, the next request is accepted at that edge. Minimum period per transaction is ADDR_WIDTH+DATA_WIDTH+1 cycles.
- Each stall cycle extends the transaction by exactly one cycle.
- The address-to-data switch has no gap: `bus_mode` rises in the same cycle as the first data beat.
- A stall during the first data cycle shows `bus_mode`=1 with valid=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `req_*` or `bus_stall` to any output except `bus_data_out_valid`, which depends on `bus_stall`.

## Test plan
- Reset, then `req_addr`=0x4123, `req_data`=0xA5, one-cycle `req_valid` -> valid beats with mode 0 are 1,1,0,0,0,1,0,0,1,0,0,0,0,0,1,0; then mode 1 beats 1,0,1,0,0,1,0,1; `done` in cycle T+25.
- `bus_stall` high for 3 cycles in mid-address (beat 5) and 2 cycles at data beat 0 -> the bit sequence is unchanged, valid drops for exactly those cycles, and `done` comes at T+30.
- Back-to-back requests 0x0012/0x3C then 0x8FFF/0xFF with `req_valid` held -> second accept on the `done` cycle; the second transaction's first beat is at T+26 with value 1.
- `req_valid` pulses while busy, and `req_addr` changes after accept -> no second capture and the original bits are transmitted; `req_ready`=0 throughout.
- Assert `rst` at data beat 3 -> the next cycle shows all outputs at reset values, no `done`; a new request afterwards transmits cleanly.
- Connected to the target address decoder, send address 0x0400 (target 1) and 0x8001 (target 3) -> the decoder asserts the matching target valid, and that valid clears after the 8th data beat.

Source files
------------

// File: rtl/serial_bus_tx.sv
// Initiator-side bus serializer: one parallel {address, data} request goes out
// as ADDR_WIDTH address beats and then DATA_WIDTH data beats, LSB first.
module serial_bus_tx #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_ready,
  input  logic                  bus_stall,
  output logic                  bus_data_out,
  output logic                  bus_data_out_valid,
  output logic                  bus_mode,
  output logic                  busy,
  output logic                  done
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  // The counter only ever reaches the last beat index of a phase, so it never wraps.
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_sh;
  logic [DATA_WIDTH-1:0]   data_sh;
  logic [CNT_W-1:0]        bit_cnt;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours, as real flops do.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_sh <= '0;
      data_sh <= '0;
      bit_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_sh <= req_addr;
            data_sh <= req_data;
            bit_cnt <= '0;
            state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!bus_stall) begin
            addr_sh <= addr_sh >> 1;
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt <= '0;
              state   <= S_DATA;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (!bus_stall) begin
            data_sh <= data_sh >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= S_IDLE;
              done    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Everything except the beat-valid strobe decodes from registered state only.
  assign busy               = (state != S_IDLE);
  assign req_ready          = (state == S_IDLE);
  assign bus_mode           = (state == S_DATA);
  assign bus_data_out       = (state == S_ADDR) ? addr_sh[0] :
                              (state == S_DATA) ? data_sh[0] : 1'b0;
  assign bus_data_out_valid = busy && !bus_stall;

endmodule
